// File: rtl/beep_scheduler.sv
// beep_scheduler: shares one buzzer between key click, hourly chime and two
// alarms. Requests are latched into pends, arbitrated by fixed priority
// (alarm1 > alarm2 > chime > click), and served as on/off phases timed on the
// 1 kHz tick. Outputs are registered selects/gates for the tone generator.
module beep_scheduler #(
  parameter int unsigned CLICK_MS         = 20,
  parameter int unsigned CHIME_ON_MS      = 150,
  parameter int unsigned CHIME_OFF_MS     = 350,
  parameter int unsigned ALARM_ON_MS      = 250,
  parameter int unsigned ALARM_OFF_MS     = 250,
  parameter int unsigned ALARM_TIMEOUT_MS = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       req_click,
  input  logic       req_chime,
  input  logic [3:0] chime_cnt,
  input  logic [1:0] req_alarm,
  input  logic       stop,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, CLICK, CHIME_ON, CHIME_OFF, ALARM_ON, ALARM_OFF
  } state_t;

  // Phase counters hold "ticks seen so far", so a phase ends on the tick where
  // the count equals its length minus one.
  localparam logic [15:0] CLICK_LAST     = 16'(CLICK_MS - 1);
  localparam logic [15:0] CHIME_ON_LAST  = 16'(CHIME_ON_MS - 1);
  localparam logic [15:0] CHIME_OFF_LAST = 16'(CHIME_OFF_MS - 1);
  localparam logic [15:0] ALARM_ON_LAST  = 16'(ALARM_ON_MS - 1);
  localparam logic [15:0] ALARM_OFF_LAST = 16'(ALARM_OFF_MS - 1);
  localparam logic [15:0] TIMEOUT_LAST   = 16'(ALARM_TIMEOUT_MS - 1);

  state_t      state, state_nx;
  logic        src_a2, src_a2_nx;          // which alarm owns ALARM_ON/OFF
  logic [15:0] phase_cnt, phase_cnt_nx;
  logic [15:0] elapsed, elapsed_nx;
  logic [3:0]  beeps, beeps_nx;
  logic [3:0]  chime_val, chime_val_nx;
  logic        pend_click, pend_click_nx;
  logic        pend_chime, pend_chime_nx;
  logic [1:0]  pend_alarm, pend_alarm_nx;
  logic [1:0]  alarm_q;
  logic        tone_en_nx, busy_nx;
  logic [1:0]  tone_sel_nx;
  logic [3:0]  grant_nx;

  logic        clr_click, clr_chime, start_alarm, start_a2, chime_set;
  logic [1:0]  clr_alarm, alarm_rise;
  logic [15:0] phase_last;
  logic        phase_end, timeout_hit, in_alarm;
  logic [3:0]  chime_clamped;

  assign alarm_rise    = req_alarm & ~alarm_q;
  assign chime_set     = req_chime && (chime_cnt != 4'd0);
  assign chime_clamped = (chime_cnt > 4'd12) ? 4'd12 : chime_cnt;
  assign in_alarm      = (state == ALARM_ON) || (state == ALARM_OFF);
  assign timeout_hit   = tick_1ms && (elapsed >= TIMEOUT_LAST);
  assign phase_end     = tick_1ms && (phase_cnt == phase_last);

  // Length of the current phase.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    phase_last = '0;
    case (state)
      CLICK:     phase_last = CLICK_LAST;
      CHIME_ON:  phase_last = CHIME_ON_LAST;
      CHIME_OFF: phase_last = CHIME_OFF_LAST;
      ALARM_ON:  phase_last = ALARM_ON_LAST;
      ALARM_OFF: phase_last = ALARM_OFF_LAST;
      default:   phase_last = '0;
    endcase
  end

  // Next-state, arbitration, pend maintenance and registered-output decode.
  always_comb begin
    state_nx    = state;
    src_a2_nx   = src_a2;
    beeps_nx    = beeps;
    clr_click   = 1'b0;
    clr_chime   = 1'b0;
    clr_alarm   = 2'b00;
    start_alarm = 1'b0;
    start_a2    = 1'b0;
    elapsed_nx  = elapsed;
    if (in_alarm && tick_1ms && (elapsed != 16'hFFFF))
      elapsed_nx = elapsed + 16'd1;

    case (state)
      IDLE: begin
        if (|pend_alarm) begin
          start_alarm = 1'b1;
          start_a2    = !pend_alarm[0];
        end else if (pend_chime) begin
          state_nx  = CHIME_ON;
          beeps_nx  = chime_val;
          clr_chime = 1'b1;
          clr_click = 1'b1;
        end else if (pend_click) begin
          state_nx  = CLICK;
          clr_click = 1'b1;
        end
      end
      CLICK, CHIME_ON, CHIME_OFF: begin
        if (stop) begin
          state_nx  = IDLE;
          clr_click = (state == CLICK);
          clr_chime = (state != CLICK);
        end else if (|pend_alarm) begin
          // Alarm preempts at once; a preempted chime is dropped outright.
          start_alarm = 1'b1;
          start_a2    = !pend_alarm[0];
          clr_chime   = (state != CLICK);
        end else if (phase_end) begin
          case (state)
            CLICK:    state_nx = IDLE;
            CHIME_ON: begin
              beeps_nx = beeps - 4'd1;
              state_nx = (beeps > 4'd1) ? CHIME_OFF : IDLE;
            end
            default:  state_nx = CHIME_ON;
          endcase
        end
      end
      ALARM_ON, ALARM_OFF: begin
        if (stop) begin
          state_nx  = IDLE;
          clr_alarm = src_a2 ? 2'b10 : 2'b01;
        end else if (src_a2 && pend_alarm[0]) begin
          // Alarm2 keeps its pend and restarts later with a fresh timeout.
          start_alarm = 1'b1;
          start_a2    = 1'b0;
        end else if (timeout_hit) begin
          state_nx  = IDLE;
          clr_alarm = src_a2 ? 2'b10 : 2'b01;
        end else if (phase_end) begin
          state_nx = (state == ALARM_ON) ? ALARM_OFF : ALARM_ON;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start_alarm) begin
      state_nx   = ALARM_ON;
      src_a2_nx  = start_a2;
      elapsed_nx = '0;
      clr_click  = 1'b1;
    end

    if (start_alarm || (state_nx != state))
      phase_cnt_nx = '0;
    else if ((state != IDLE) && tick_1ms)
      phase_cnt_nx = phase_cnt + 16'd1;
    else
      phase_cnt_nx = phase_cnt;

    // A new request in the same cycle as a clear wins, so it is never lost.
    pend_click_nx = (pend_click & ~clr_click) | req_click;
    pend_chime_nx = (pend_chime & ~clr_chime) | chime_set;
    chime_val_nx  = chime_set ? chime_clamped : chime_val;
    pend_alarm_nx = (pend_alarm & ~clr_alarm) | alarm_rise;

    busy_nx     = (state_nx != IDLE);
    tone_en_nx  = (state_nx == CLICK) || (state_nx == CHIME_ON) || (state_nx == ALARM_ON);
    tone_sel_nx = 2'd0;
    grant_nx    = 4'b0000;
    case (state_nx)
      CLICK:               begin tone_sel_nx = 2'd0; grant_nx = 4'b0001; end
      CHIME_ON, CHIME_OFF: begin tone_sel_nx = 2'd1; grant_nx = 4'b0010; end
      ALARM_ON, ALARM_OFF: begin
        tone_sel_nx = src_a2_nx ? 2'd3 : 2'd2;
        grant_nx    = src_a2_nx ? 4'b1000 : 4'b0100;
      end
      default:             begin tone_sel_nx = 2'd0; grant_nx = 4'b0000; end
    endcase
  end

  // State, counters, pends and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      // NOTE: every register, including pend storage, is reset; the edge detector
      // loads the live level so an alarm already high at release does not fire.
      state      <= IDLE;
      src_a2     <= 1'b0;
      phase_cnt  <= '0;
      elapsed    <= '0;
      beeps      <= '0;
      chime_val  <= '0;
      pend_click <= 1'b0;
      pend_chime <= 1'b0;
      pend_alarm <= 2'b00;
      alarm_q    <= req_alarm;
      tone_en    <= 1'b0;
      tone_sel   <= 2'd0;
      grant      <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      src_a2     <= src_a2_nx;
      phase_cnt  <= phase_cnt_nx;
      elapsed    <= elapsed_nx;
      beeps      <= beeps_nx;
      chime_val  <= chime_val_nx;
      pend_click <= pend_click_nx;
      pend_chime <= pend_chime_nx;
      pend_alarm <= pend_alarm_nx;
      alarm_q    <= req_alarm;
      tone_en    <= tone_en_nx;
      tone_sel   <= tone_sel_nx;
      grant      <= grant_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_beep_scheduler.sv
// Self-checking bench for beep_scheduler: directed scenarios plus randomized
// traffic, compared every cycle against a service-level reference model.
module tb_beep_scheduler;

  localparam int CLICK_MS     = 3;
  localparam int CHIME_ON_MS  = 4;
  localparam int CHIME_OFF_MS = 5;
  localparam int ALARM_ON_MS  = 3;
  localparam int ALARM_OFF_MS = 2;
  localparam int TO_MS        = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_1ms, req_click, req_chime, stop;
  logic [3:0] chime_cnt;
  logic [1:0] req_alarm;
  logic       tone_en, busy;
  logic [1:0] tone_sel;
  logic [3:0] grant;

  beep_scheduler #(
    .CLICK_MS(CLICK_MS), .CHIME_ON_MS(CHIME_ON_MS), .CHIME_OFF_MS(CHIME_OFF_MS),
    .ALARM_ON_MS(ALARM_ON_MS), .ALARM_OFF_MS(ALARM_OFF_MS), .ALARM_TIMEOUT_MS(TO_MS)
  ) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .req_click(req_click),
    .req_chime(req_chime), .chime_cnt(chime_cnt), .req_alarm(req_alarm),
    .stop(stop), .tone_en(tone_en), .tone_sel(tone_sel), .grant(grant), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model: who is being served, whether the buzzer is sounding,
  // ticks left in the current on/off period, beeps left, alarm time used.
  int   m_src;          // 0 none, 1 click, 2 chime, 3 alarm1, 4 alarm2
  bit   m_on;
  int   m_left, m_beeps, m_elapsed, p_val;
  bit   p_click, p_chime, p_a1, p_a2;
  bit   c_click, c_chime, c_a1, c_a2;
  logic [1:0] m_aq;

  int   on_ticks, busy_ticks, bursts;
  bit   prev_en;
  logic [1:0] al_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_src == 0) ? 4'b0000 : 4'(1 << (m_src - 1));
    s = (m_src == 0) ? 2'd0 : 2'(m_src - 1);
    return {(m_src != 0), (m_src != 0) && m_on, s, g};
  endfunction

  task automatic start_alarm(input int s);
    m_src = s; m_on = 1'b1; m_left = ALARM_ON_MS; m_elapsed = 0; c_click = 1'b1;
  endtask

  task automatic end_service();
    case (m_src)
      1: c_click = 1'b1;
      2: c_chime = 1'b1;
      3: c_a1 = 1'b1;
      4: c_a2 = 1'b1;
      default: ;
    endcase
    m_src = 0;
  endtask

  task automatic model_update(input logic r, c, ch, input logic [3:0] cnt,
                              input logic [1:0] al, input logic st, tk);
    bit rise1, rise2;
    if (r) begin
      m_src = 0; m_on = 0; m_left = 0; m_beeps = 0; m_elapsed = 0; p_val = 0;
      p_click = 0; p_chime = 0; p_a1 = 0; p_a2 = 0; m_aq = al;
      return;
    end
    rise1 = al[0] && !m_aq[0];
    rise2 = al[1] && !m_aq[1];
    m_aq = al;
    c_click = 0; c_chime = 0; c_a1 = 0; c_a2 = 0;
    if (m_src == 0) begin
      if (p_a1) start_alarm(3);
      else if (p_a2) start_alarm(4);
      else if (p_chime) begin
        m_src = 2; m_on = 1; m_left = CHIME_ON_MS; m_beeps = p_val; c_chime = 1; c_click = 1;
      end else if (p_click) begin
        m_src = 1; m_on = 1; m_left = CLICK_MS; c_click = 1;
      end
    end else if (st) begin
      end_service();
    end else if (m_src <= 2 && (p_a1 || p_a2)) begin
      if (m_src == 2) c_chime = 1;
      start_alarm(p_a1 ? 3 : 4);
    end else if (m_src == 4 && p_a1) begin
      start_alarm(3);
    end else if (tk) begin
      if (m_src >= 3) begin
        m_elapsed++;
        if (m_elapsed >= TO_MS) end_service();
        else begin
          m_left--;
          if (m_left == 0) begin
            m_on = !m_on;
            m_left = m_on ? ALARM_ON_MS : ALARM_OFF_MS;
          end
        end
      end else if (m_src == 2) begin
        m_left--;
        if (m_left == 0) begin
          if (m_on) begin
            m_beeps--;
            if (m_beeps > 0) begin m_on = 0; m_left = CHIME_OFF_MS; end
            else m_src = 0;
          end else begin
            m_on = 1; m_left = CHIME_ON_MS;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_src = 0;
      end
    end
    p_click = (p_click && !c_click) || c;
    p_chime = (p_chime && !c_chime) || (ch && cnt != 0);
    if (ch && cnt != 0) p_val = (cnt > 12) ? 12 : int'(cnt);
    p_a1 = (p_a1 && !c_a1) || rise1;
    p_a2 = (p_a2 && !c_a2) || rise2;
  endtask

  task automatic step(input logic r, c, ch, input logic [3:0] cnt,
                      input logic [1:0] al, input logic st, tk);
    if (tk && busy) busy_ticks++;
    if (tk && tone_en) on_ticks++;
    if (tone_en && !prev_en) bursts++;
    prev_en = tone_en;
    rst = r; req_click = c; req_chime = ch; chime_cnt = cnt;
    req_alarm = al; stop = st; tick_1ms = tk;
    @(posedge clk);
    model_update(r, c, ch, cnt, al, st, tk);
    @(negedge clk);
    cyc++;
    check("out", {24'd0, busy, tone_en, tone_sel, grant}, {24'd0, model_vec()});
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, al_lvl, 0, (cyc % 2) == 0);
  endtask

  task automatic until_idle(input string tag, input int max);
    int k;
    k = 0;
    while (busy && k < max) begin
      quiet(1);
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_stats();
    on_ticks = 0; busy_ticks = 0; bursts = 0;
  endtask

  int exp_on, exp_bursts, k;

  initial begin
    rst = 1; tick_1ms = 0; req_click = 0; req_chime = 0; chime_cnt = 0;
    req_alarm = 2'b01; stop = 0; al_lvl = 2'b01; prev_en = 0;
    clear_stats();
    @(negedge clk);

    // Reset with alarm1 level already high; release must not fire it.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd0, 2'b01, 0, 0);
    check("reset_outputs", {24'd0, busy, tone_en, tone_sel, grant}, 32'd0);
    quiet(10);
    check("no_alarm_at_release", {31'd0, busy}, 32'd0);
    al_lvl = 2'b00;
    quiet(3);

    // Click.
    clear_stats();
    step(0, 1, 0, 4'd0, al_lvl, 0, 0);
    step(0, 0, 0, 4'd0, al_lvl, 0, 0);
    check("click_grant", {28'd0, grant}, 32'd1);
    check("click_tone", {31'd0, tone_en}, 32'd1);
    check("click_sel", {30'd0, tone_sel}, 32'd0);
    until_idle("click_end", 200);
    check("click_ticks", on_ticks, CLICK_MS);

    // Chime counts 3, 15 (clamped to 12), 0.
    clear_stats();
    step(0, 0, 1, 4'd3, al_lvl, 0, 0);
    quiet(1);
    until_idle("chime3_end", 500);
    check("chime3_bursts", bursts, 3);
    check("chime3_on_ticks", on_ticks, 3 * CHIME_ON_MS);
    check("chime3_busy_ticks", busy_ticks, 3 * CHIME_ON_MS + 2 * CHIME_OFF_MS);
    clear_stats();
    step(0, 0, 1, 4'd15, al_lvl, 0, 0);
    quiet(1);
    until_idle("chime15_end", 2000);
    check("chime15_bursts", bursts, 12);
    clear_stats();
    step(0, 0, 1, 4'd0, al_lvl, 0, 0);
    quiet(6);
    check("chime0_bursts", bursts + busy_ticks, 0);

    // Alarm2 held: on/off pattern until timeout, no re-arm, re-arm on new edge.
    exp_on = 0; exp_bursts = 0;
    for (int t = 0; t < TO_MS; t++) begin
      if ((t % (ALARM_ON_MS + ALARM_OFF_MS)) < ALARM_ON_MS) exp_on++;
      if ((t % (ALARM_ON_MS + ALARM_OFF_MS)) == 0) exp_bursts++;
    end
    al_lvl = 2'b10;
    clear_stats();
    quiet(2);
    check("alarm2_sel", {30'd0, tone_sel}, 32'd3);
    until_idle("alarm2_timeout", 1000);
    check("alarm2_busy_ticks", busy_ticks, TO_MS);
    check("alarm2_on_ticks", on_ticks, exp_on);
    check("alarm2_bursts", bursts, exp_bursts);
    clear_stats();
    quiet(40);
    check("alarm2_no_rearm", busy_ticks + bursts, 0);
    al_lvl = 2'b00; quiet(2);
    al_lvl = 2'b10; quiet(3);
    check("alarm2_rearm", {28'd0, grant}, 32'h8);

    // Alarm1 preempts alarm2; after stop, alarm2 resumes with a fresh timeout.
    quiet(5);
    al_lvl = 2'b11;
    quiet(2);
    check("a1_preempt_grant", {28'd0, grant}, 32'h4);
    check("a1_preempt_sel", {30'd0, tone_sel}, 32'd2);
    quiet(4);
    step(0, 0, 0, 4'd0, al_lvl, 1, 0);
    check("a1_stopped", {31'd0, busy}, 32'd0);
    clear_stats();
    quiet(2);
    check("a2_resume", {28'd0, grant}, 32'h8);
    until_idle("a2_resume_end", 1000);
    check("a2_fresh_timeout", busy_ticks, TO_MS);
    al_lvl = 2'b00;
    quiet(3);

    // Chime interrupted in its gap by alarm1: dropped, no continuation after stop.
    step(0, 0, 1, 4'd3, al_lvl, 0, 0);
    k = 0;
    while (!(busy && !tone_en) && k < 200) begin quiet(1); k++; end
    check("chime_gap_reached", {31'd0, busy && !tone_en}, 32'd1);
    al_lvl = 2'b01;
    quiet(2);
    check("chime_preempted", {28'd0, grant}, 32'h4);
    quiet(3);
    step(0, 0, 0, 4'd0, al_lvl, 1, 0);
    clear_stats();
    quiet(30);
    check("no_chime_resume", busy_ticks + bursts, 0);

    // Reset during ALARM_ON with level held through reset.
    al_lvl = 2'b00; quiet(2);
    al_lvl = 2'b01;
    k = 0;
    while (!tone_en && k < 50) begin quiet(1); k++; end
    check("alarm_on_reached", {31'd0, tone_en}, 32'd1);
    step(1, 0, 0, 4'd0, al_lvl, 0, 0);
    check("mid_reset_outputs", {24'd0, busy, tone_en, tone_sel, grant}, 32'd0);
    step(1, 0, 0, 4'd0, al_lvl, 0, 0);
    clear_stats();
    quiet(10);
    check("no_retrigger_after_reset", busy_ticks + bursts, 0);
    al_lvl = 2'b00;
    quiet(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      logic [3:0] cnt;
      if ($urandom_range(0, 149) == 0) al_lvl[0] = ~al_lvl[0];
      if ($urandom_range(0, 149) == 0) al_lvl[1] = ~al_lvl[1];
      cnt = 4'($urandom_range(0, 15));
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 79) == 0, cnt, al_lvl,
           $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
